// File: rtl/video_shifter.sv
// Video dot shifter: loads one display byte per LDPS_N strobe and serialises
// text (via character ROM), hires or lores dots onto VIDEO at 14M.
module video_shifter #(
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic        CLK_14M,
    input  logic        RESET_N,
    input  logic        VID7M,
    input  logic        LDPS_N,
    input  logic [7:0]  DL,
    input  logic        GR2,
    input  logic        HIRES_MODE,
    input  logic        ALTCHAR,
    input  logic        SEGA,
    input  logic        SEGB,
    input  logic        SEGC,
    input  logic        WNDW_N,
    input  logic        VBLANK,
    output logic [10:0] CHAR_ROM_ADDR,
    input  logic [7:0]  CHAR_ROM_DATA,
    output logic        VIDEO,
    output logic        FLASH
);

    typedef enum logic [1:0] {
        MODE_TEXT  = 2'd0,
        MODE_HIRES = 2'd1,
        MODE_LORES = 2'd2
    } mode_t;

    localparam int unsigned FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    mode_t          mode_q, mode_d;
    logic [6:0]     shift_q, shift_d;
    logic [3:0]     nib_q, nib_d;
    logic [1:0]     lores_cnt_q, lores_cnt_d;
    logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
    logic           delay_q, delay_d;
    logic           blank_q, blank_d;
    logic           flash_q, flash_d;
    logic           video_q, video_d;
    logic           prev_dot_q;
    logic           ldps_q;
    logic           vblank_q;
    logic           load;
    logic           inv;
    logic           pixel;
    logic           unused_rom_bit7;

    assign CHAR_ROM_ADDR   = {DL, SEGC, SEGB, SEGA};
    assign VIDEO           = video_q;
    assign FLASH           = flash_q;
    assign unused_rom_bit7 = CHAR_ROM_DATA[7];

    always_comb begin
        mode_d      = mode_q;
        shift_d     = shift_q;
        nib_d       = nib_q;
        lores_cnt_d = lores_cnt_q;
        delay_d     = delay_q;
        blank_d     = blank_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        pixel       = 1'b0;
        inv         = 1'b0;

        load = ~LDPS_N & ldps_q;

        if (DL[7:6] == 2'b00) begin
            inv = 1'b1;
        end else if (DL[7:6] == 2'b01 && !ALTCHAR) begin
            inv = flash_q;
        end

        if (load) begin
            if (!GR2) begin
                mode_d = MODE_TEXT;
            end else if (HIRES_MODE) begin
                mode_d = MODE_HIRES;
            end else begin
                mode_d = MODE_LORES;
            end
            shift_d     = GR2 ? DL[6:0] : (CHAR_ROM_DATA[6:0] ^ {7{inv}});
            nib_d       = SEGC ? DL[7:4] : DL[3:0];
            lores_cnt_d = {SEGA, 1'b0};
            delay_d     = DL[7];
            blank_d     = WNDW_N;
        end else begin
            if (VID7M) begin
                shift_d = {1'b0, shift_q[6:1]};
            end
            // lores phase runs at full 14M rate regardless of VID7M
            lores_cnt_d = lores_cnt_q + 2'd1;
        end

        case (mode_q)
            MODE_HIRES: pixel = delay_q ? prev_dot_q : shift_q[0];
            MODE_LORES: pixel = nib_q[lores_cnt_q];
            default:    pixel = shift_q[0];
        endcase
        video_d = blank_q ? 1'b0 : pixel;

        if (VBLANK && !vblank_q) begin
            if (flash_cnt_q == FCW'(FLASH_FRAMES - 1)) begin
                flash_cnt_d = '0;
                flash_d     = ~flash_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_14M) begin
        if (!RESET_N) begin
            mode_q      <= MODE_TEXT;
            shift_q     <= '0;
            nib_q       <= '0;
            lores_cnt_q <= '0;
            flash_cnt_q <= '0;
            delay_q     <= 1'b0;
            blank_q     <= 1'b1;
            flash_q     <= 1'b0;
            video_q     <= 1'b0;
            prev_dot_q  <= 1'b0;
            ldps_q      <= 1'b1;
            vblank_q    <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            nib_q       <= nib_d;
            lores_cnt_q <= lores_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            delay_q     <= delay_d;
            blank_q     <= blank_d;
            flash_q     <= flash_d;
            video_q     <= video_d;
            prev_dot_q  <= shift_q[0];
            ldps_q      <= LDPS_N;
            vblank_q    <= VBLANK;
        end
    end

endmodule

// File: tb/tb_video_shifter.sv
// Directed and randomized checks of video_shifter against a dot-stream model.
module tb_video_shifter;

    localparam int unsigned FF = 16;

    logic        CLK_14M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        VID7M = 1'b0;
    logic        LDPS_N = 1'b1;
    logic [7:0]  DL = 8'h00;
    logic        GR2 = 1'b0;
    logic        HIRES_MODE = 1'b0;
    logic        ALTCHAR = 1'b0;
    logic        SEGA = 1'b0;
    logic        SEGB = 1'b0;
    logic        SEGC = 1'b0;
    logic        WNDW_N = 1'b0;
    logic        VBLANK = 1'b0;
    logic [10:0] CHAR_ROM_ADDR;
    logic [7:0]  CHAR_ROM_DATA;
    logic        VIDEO;
    logic        FLASH;

    logic [7:0] rom [0:2047];
    assign CHAR_ROM_DATA = rom[CHAR_ROM_ADDR];

    always #5 CLK_14M = ~CLK_14M;

    video_shifter #(.FLASH_FRAMES(FF)) dut (
        .CLK_14M       (CLK_14M),
        .RESET_N       (RESET_N),
        .VID7M         (VID7M),
        .LDPS_N        (LDPS_N),
        .DL            (DL),
        .GR2           (GR2),
        .HIRES_MODE    (HIRES_MODE),
        .ALTCHAR       (ALTCHAR),
        .SEGA          (SEGA),
        .SEGB          (SEGB),
        .SEGC          (SEGC),
        .WNDW_N        (WNDW_N),
        .VBLANK        (VBLANK),
        .CHAR_ROM_ADDR (CHAR_ROM_ADDR),
        .CHAR_ROM_DATA (CHAR_ROM_DATA),
        .VIDEO         (VIDEO),
        .FLASH         (FLASH)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: the current byte is a list of dots indexed by how many
    // VID7M shifts (text/hires) or 14M cycles (lores) have elapsed since its load.
    bit         m_ldps_prev;
    int         m_mode;          // 0 text, 1 hires, 2 lores
    bit         m_blank;
    bit         m_delay;
    logic [6:0] m_dots;
    int         m_shifts;
    int         m_k;
    logic [3:0] m_nib;
    int         m_phase;
    bit         m_last_raw;
    int         m_rises;
    bit         m_vb_prev;

    function automatic bit cur_dot();
        if (m_shifts < 7) return m_dots[3'(m_shifts)];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ldps_prev = 1'b1;
        m_mode      = 0;
        m_blank     = 1'b1;
        m_delay     = 1'b0;
        m_dots      = '0;
        m_shifts    = 7;
        m_k         = 0;
        m_nib       = '0;
        m_phase     = 0;
        m_last_raw  = 1'b0;
        m_rises     = 0;
        m_vb_prev   = 1'b0;
    endtask

    task automatic model_edge(output bit ev, output bit ef);
        bit pix;
        bit flash_now;
        bit inv;
        logic [7:0] romv;
        if (!RESET_N) begin
            model_reset();
            ev = 1'b0;
            ef = 1'b0;
            return;
        end
        if (m_mode == 2)                pix = m_nib[2'((m_k + 2 * m_phase) % 4)];
        else if (m_mode == 1 && m_delay) pix = m_last_raw;
        else                            pix = cur_dot();
        ev = m_blank ? 1'b0 : pix;

        flash_now  = ((m_rises / FF) % 2) == 1;
        m_last_raw = cur_dot();
        if (!LDPS_N && m_ldps_prev) begin
            m_mode  = !GR2 ? 0 : (HIRES_MODE ? 1 : 2);
            m_blank = WNDW_N;
            m_delay = DL[7];
            m_nib   = SEGC ? DL[7:4] : DL[3:0];
            m_phase = SEGA ? 1 : 0;
            m_k     = 0;
            m_shifts = 0;
            if (GR2) begin
                m_dots = DL[6:0];
            end else begin
                if (DL[7:6] == 2'b00)                 inv = 1'b1;
                else if (DL[7:6] == 2'b01 && !ALTCHAR) inv = flash_now;
                else                                  inv = 1'b0;
                romv   = rom[{DL, SEGC, SEGB, SEGA}];
                m_dots = romv[6:0] ^ {7{inv}};
            end
        end else begin
            m_k++;
            if (VID7M && m_shifts < 7) m_shifts++;
        end
        m_ldps_prev = LDPS_N;
        if (VBLANK && !m_vb_prev) m_rises++;
        m_vb_prev = VBLANK;
        ef = ((m_rises / FF) % 2) == 1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, output logic v);
        bit ev, ef;
        logic [10:0] ea;
        ea = {DL, SEGC, SEGB, SEGA};
        model_edge(ev, ef);
        @(posedge CLK_14M);
        #1;
        chk({tag, ":video"}, 11'(VIDEO), 11'(ev));
        chk({tag, ":flash"}, 11'(FLASH), 11'(ef));
        chk({tag, ":rom_addr"}, CHAR_ROM_ADDR, ea);
        v = VIDEO;
    endtask

    // vmode: 0 = VID7M alternating (high on the load edge), 1 = always high, 2 = random
    task automatic run_byte(input logic [7:0] d, input int cycles, input int low_len,
                            input int vmode, input string tag, output logic [31:0] cap);
        logic v;
        cap = '0;
        DL  = d;
        for (int i = 0; i < cycles; i++) begin
            LDPS_N = (i < low_len) ? 1'b0 : 1'b1;
            case (vmode)
                0:       VID7M = (i % 2 == 0);
                1:       VID7M = 1'b1;
                default: begin
                    VID7M  = 1'($urandom % 2);
                    VBLANK = ($urandom % 6) == 0;
                end
            endcase
            step(tag, v);
            cap[i] = v;
        end
    endtask

    task automatic idle(input int n, input string tag);
        logic v;
        LDPS_N = 1'b1;
        for (int i = 0; i < n; i++) step(tag, v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] cap;
        logic [31:0] cap2;
        logic        v;

        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        rom[{8'hC1, 3'b000}] = 8'h55;
        rom[{8'h41, 3'b000}] = 8'h55;
        rom[{8'h01, 3'b000}] = 8'h55;
        model_reset();

        RESET_N = 1'b0;
        step("reset0", v);
        step("reset1", v);
        RESET_N = 1'b1;
        idle(3, "post_reset");

        // Text byte 0xC1 / ROM 0x55 with VID7M at half rate
        run_byte(8'hC1, 16, 1, 0, "t1_text", cap);
        for (int i = 1; i <= 14; i++) chk("t1_pattern", 11'(cap[i]), 11'(((i - 1) / 2) % 2 == 0));

        // Flash counter: 16 VBLANK rising edges toggle FLASH once
        for (int p = 1; p <= 16; p++) begin
            VBLANK = 1'b1; step("t2_vb", v); step("t2_vb", v);
            VBLANK = 1'b0; step("t2_vb", v); step("t2_vb", v);
            if (p == 15) chk("t2_flash_after15", 11'(FLASH), 11'(0));
        end
        chk("t2_flash_after16", 11'(FLASH), 11'(1));
        ALTCHAR = 1'b0;
        run_byte(8'h41, 16, 1, 0, "t2_flashchar", cap);
        chk("t2_flash_inv_d0", 11'(cap[1]), 11'(0));
        chk("t2_flash_inv_d1", 11'(cap[3]), 11'(1));
        run_byte(8'h01, 16, 1, 0, "t2_inverse", cap);
        chk("t2_inverse_d0", 11'(cap[1]), 11'(0));
        ALTCHAR = 1'b1;
        run_byte(8'h41, 16, 1, 0, "t2_altchar", cap);
        chk("t2_altchar_d0", 11'(cap[1]), 11'(1));
        ALTCHAR = 1'b0;

        // Hires delay bit
        GR2 = 1'b1; HIRES_MODE = 1'b1;
        run_byte(8'h7F, 7, 1, 1, "t3_hires_a", cap);
        run_byte(8'h80, 7, 1, 1, "t3_hires_b", cap2);
        chk("t3_first_dot", 11'(cap[1]), 11'(1));
        chk("t3_delayed_carry", 11'(cap2[1]), 11'(1));
        chk("t3_delayed_dot0", 11'(cap2[2]), 11'(0));

        // Lores nibble selection and phase
        HIRES_MODE = 1'b0; SEGA = 1'b1; SEGC = 1'b0;
        run_byte(8'h5A, 15, 1, 0, "t4_lores_lo", cap);
        for (int i = 1; i <= 14; i++) chk("t4_lores_lo", 11'(cap[i]), 11'((i - 1) % 2));
        SEGC = 1'b1;
        run_byte(8'h5A, 15, 1, 0, "t4_lores_hi", cap);
        for (int i = 1; i <= 14; i++) chk("t4_lores_hi", 11'(cap[i]), 11'(i % 2));

        // Blanking latched at load; long LDPS_N low loads once
        GR2 = 1'b0; HIRES_MODE = 1'b0; SEGA = 1'b0; SEGC = 1'b0; WNDW_N = 1'b1;
        run_byte(8'hC1, 14, 1, 0, "t5_blank", cap);
        for (int i = 1; i <= 13; i++) chk("t5_blanked", 11'(cap[i]), 11'(0));
        WNDW_N = 1'b0;
        run_byte(8'hC1, 10, 3, 1, "t5_longlow", cap);
        chk("t5_single_load_d0", 11'(cap[1]), 11'(1));
        chk("t5_single_load_d1", 11'(cap[2]), 11'(0));
        chk("t5_single_load_d2", 11'(cap[3]), 11'(1));
        chk("t5_single_load_d3", 11'(cap[4]), 11'(0));

        // Reset in the middle of a line
        run_byte(8'hC1, 5, 1, 0, "t6_pre", cap);
        RESET_N = 1'b0; LDPS_N = 1'b1;
        step("t6_reset", v);
        chk("t6_video_reset", 11'(VIDEO), 11'(0));
        chk("t6_flash_reset", 11'(FLASH), 11'(0));
        RESET_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            VID7M = (i % 2 == 0);
            step("t6_idle", v);
            chk("t6_video_held", 11'(v), 11'(0));
        end
        run_byte(8'hC1, 14, 1, 0, "t6_reload", cap);
        chk("t6_reload_d0", 11'(cap[1]), 11'(1));

        // Random text / hires bytes
        for (int b = 0; b < 40; b++) begin
            GR2        = 1'($urandom % 2);
            HIRES_MODE = GR2 ? 1'b1 : 1'($urandom % 2);
            ALTCHAR    = 1'($urandom % 2);
            SEGA       = 1'($urandom % 2);
            SEGB       = 1'($urandom % 2);
            SEGC       = 1'($urandom % 2);
            WNDW_N     = ($urandom % 5) == 0;
            run_byte(8'($urandom), int'($urandom_range(16, 6)), int'($urandom_range(2, 1)), 2,
                     "rand_th", cap);
        end

        // Random lores bytes
        GR2 = 1'b1; HIRES_MODE = 1'b0;
        for (int b = 0; b < 20; b++) begin
            SEGA   = 1'($urandom % 2);
            SEGB   = 1'($urandom % 2);
            SEGC   = 1'($urandom % 2);
            WNDW_N = ($urandom % 5) == 0;
            run_byte(8'($urandom), int'($urandom_range(20, 6)), int'($urandom_range(2, 1)), 2,
                     "rand_lores", cap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
